// File: rtl/gj_pkg.sv
// Shared definitions for the gap-junction Aurora test-frame path.
// Used by the RX stream checker and its TX frame-generator counterpart.
//   HDR_MAGIC   : upper half of every header beat
//   chk_state_t : checker state encoding
//   exp_word()  : expected beat for a given sequence number and beat index
package gj_pkg;

   localparam logic [15:0] HDR_MAGIC = 16'hCAFE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HUNT  = 2'd1,
      CHECK = 2'd2,
      DRAIN = 2'd3
   } chk_state_t;

   // Beat 0 is the header {magic, seq}; every later beat is {seq, idx}.
   function automatic logic [31:0] exp_word(input logic [15:0] seq, input logic [15:0] idx);
      return (idx == 16'd0) ? {HDR_MAGIC, seq} : {seq, idx};
   endfunction

endpackage

// File: rtl/gj_stream_checker.sv
// Receive-side frame checker for the Aurora RX user stream (no backpressure).
// Checks header magic, sequence continuity, payload and tlast placement of
// fixed-length test frames; keeps a saturating error count and a good-frame count.
// Ports:
//   clk, peripheral_reset   : user clock, synchronous active-high reset
//   channel_up              : link status; low forces IDLE
//   s_axis_tdata/tvalid/tlast : RX stream, every valid beat consumed
//   error_count             : saturating count of frame errors
//   frame_count             : frames accepted, wraps at 2^16
//   locked                  : high while in CHECK
//   err_pulse               : one-cycle strobe per counted error
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | link down or just reset; input ignored
// HUNT  | searching for a header beat to lock onto
// CHECK | locked; every beat compared against the expected word
// DRAIN | after an error, discard beats up to the next tlast
module gj_stream_checker
   import gj_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int FRAME_LEN = 16,
   parameter int ERR_W     = 4
) (
   input  logic              clk,
   input  logic              peripheral_reset,
   input  logic              channel_up,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic [ERR_W-1:0]  error_count,
   output logic [15:0]       frame_count,
   output logic              locked,
   output logic              err_pulse
);

   localparam logic [15:0]      LAST_IDX = 16'(FRAME_LEN - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   chk_state_t  state, state_nx;
   logic [15:0] beat_idx, beat_idx_nx;
   logic [15:0] exp_seq, exp_seq_nx;
   logic        frame_err, frame_err_nx;
   logic        count_err, frame_ok;
   logic        is_hdr, is_last, bad, abort, err_seen;

   always_ff @(posedge clk) begin
      if (peripheral_reset) begin
         state       <= IDLE;
         beat_idx    <= '0;
         exp_seq     <= '0;
         frame_err   <= 1'b0;
         error_count <= '0;
         frame_count <= '0;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         state     <= state_nx;
         beat_idx  <= beat_idx_nx;
         exp_seq   <= exp_seq_nx;
         frame_err <= frame_err_nx;
         err_pulse <= count_err;
         if (count_err && (error_count != ERR_MAX))
            error_count <= error_count + 1'b1;
         if (frame_ok)
            frame_count <= frame_count + 16'd1;
         // Mirrors the state register so locked is exactly "state == CHECK".
         locked <= (state_nx == CHECK);
      end
   end

   always_comb begin
      state_nx     = state;
      beat_idx_nx  = beat_idx;
      exp_seq_nx   = exp_seq;
      frame_err_nx = frame_err;
      count_err    = 1'b0;
      frame_ok     = 1'b0;
      is_hdr       = (beat_idx == 16'd0);
      is_last      = (beat_idx == LAST_IDX);
      bad          = 1'b0;
      abort        = 1'b0;
      // A header beat starts a fresh frame, so earlier error history is dropped.
      err_seen     = is_hdr ? 1'b0 : frame_err;

      if (!channel_up) begin
         state_nx    = IDLE;
         beat_idx_nx = '0;
      end else begin
         case (state)
            IDLE: state_nx = HUNT;
            HUNT: begin
               if (s_axis_tvalid && (s_axis_tdata[31:16] == HDR_MAGIC) && !s_axis_tlast) begin
                  exp_seq_nx   = s_axis_tdata[15:0];
                  beat_idx_nx  = 16'd1;
                  frame_err_nx = 1'b0;
                  state_nx     = CHECK;
               end
            end
            CHECK: begin
               if (s_axis_tvalid) begin
                  if (is_hdr) begin
                     if (s_axis_tdata[31:16] != HDR_MAGIC) begin
                        bad   = 1'b1;
                        abort = 1'b1;
                     end else if (s_axis_tdata[15:0] != exp_seq) begin
                        // Sequence gap: resynchronise and keep checking this frame.
                        bad        = 1'b1;
                        exp_seq_nx = s_axis_tdata[15:0];
                     end
                  end else if (s_axis_tdata != exp_word(exp_seq, beat_idx)) begin
                     bad   = 1'b1;
                     abort = 1'b1;
                  end
                  if (!abort && (s_axis_tlast != is_last)) begin
                     bad   = 1'b1;
                     abort = 1'b1;
                  end
                  count_err    = bad && !err_seen;
                  frame_err_nx = bad || err_seen;
                  if (abort) begin
                     // A failing beat that already carries tlast ends the frame itself.
                     beat_idx_nx = '0;
                     state_nx    = s_axis_tlast ? HUNT : DRAIN;
                  end else if (is_last) begin
                     frame_ok    = 1'b1;
                     exp_seq_nx  = exp_seq + 16'd1;
                     beat_idx_nx = '0;
                  end else begin
                     beat_idx_nx = beat_idx + 16'd1;
                  end
               end
            end
            DRAIN: begin
               if (s_axis_tvalid && s_axis_tlast)
                  state_nx = HUNT;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
